onehot_dispatch_decoder: RTL and testbench
==========================================

ONEHOT_DISPATCH_DECODER -- requirements
Module: onehot_dispatch_decoder

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, meaning: number of consecutive cycles each one-hot grant is held; legal range 1..256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  requester presents a 3-bit index.
REQ-005 in_code  input  3  binary index to decode (0..7).
REQ-006 in_ready  output  1  block can accept in_code this cycle.
REQ-007 out_onehot  output  8  decoded grant; bit in_code set while granting, else all zero.
REQ-008 out_valid  output  1  grant active.
REQ-009 done  output  1  single-cycle pulse on last cycle of a grant.
REQ-010 busy  output  1  grant active, gap in progress, or pending entry held.
REQ-011 grant_count  output  16  number of completed grants.

Function
REQ-012 Transfer SHALL occur when in_valid && in_ready at a rising edge; in_code sampled only then.
REQ-013 Block SHALL contain a one-entry pending register (pend_valid, pend_code); in_ready SHALL equal !pend_valid, combinationally.
REQ-014 FSM states SHALL be IDLE, ACTIVE, GAP.
REQ-015 IDLE: on transfer, next state ACTIVE, active code = in_code, hold counter loaded HOLD_CYCLES-1; pending stays empty.
REQ-016 Latency: out_onehot SHALL show 1<<code in the first cycle after the transfer edge.
REQ-017 ACTIVE: out_valid=1, out_onehot=1<<active code; counter decrements each cycle; transfer in ACTIVE loads pending register.
REQ-018 ACTIVE with counter==0: done=1 that cycle; next state GAP; counter saturates, never wraps.
REQ-019 Each grant SHALL last exactly HOLD_CYCLES cycles; HOLD_CYCLES=1 gives one ACTIVE cycle with done=1.
REQ-020 GAP: exactly one cycle, out_onehot=0, out_valid=0; grant_count increments by 1 (16-bit wrap 0xFFFF->0x0000).
REQ-021 GAP exit, priority order: pend_valid -> ACTIVE with pend_code, pend cleared; else transfer in GAP -> ACTIVE with in_code (bypass, pend stays empty); else -> IDLE.
REQ-022 Same-edge pending drain and new transfer SHALL not occur: in_ready is low whenever pend_valid=1.
REQ-023 Order SHALL be preserved: grants issue in transfer order, none dropped or duplicated.
REQ-024 busy = (state!=IDLE) || pend_valid.
REQ-025 Any in_code value 0..7 legal; no illegal-input condition exists.

Reset
REQ-026 While rst=1: state IDLE, out_onehot=0, out_valid=0, done=0, pend_valid=0, pend_code=0, counter=0, grant_count=0; in_ready=1.
REQ-027 rst assertion mid-grant SHALL abort immediately (asynchronous) with no done pulse and no grant_count increment; pending entry discarded.
REQ-028 First transfer possible at first rising edge with rst low.

Verification (HOLD_CYCLES=4 unless noted)
REQ-029 Single grant: in_code=5 transferred at edge 0 -> out_onehot=8'b00100000 cycles 1-4, done in cycle 4, cycle 5 zero, grant_count=1, IDLE cycle 6.
REQ-030 Back-to-back: code 2 then code 7 during ACTIVE -> pend holds 7, in_ready=0 until GAP drains; 8'h04 x4, one zero cycle, 8'h80 x4; grant_count=2.
REQ-031 Bypass: code 0 ends, code 3 presented in GAP with pend empty -> 8'h08 starts cycle after GAP, no extra IDLE cycle.
REQ-032 Backpressure: in_valid held high with codes 1,2,3 streaming -> each accepted once, outputs 8'h02,8'h04,8'h08 in order, no loss.
REQ-033 HOLD_CYCLES=1: codes 6,6 -> 8'h40, zero, 8'h40, zero; done high in each ACTIVE cycle.
REQ-034 Reset mid-grant: rst pulsed in cycle 2 of code 4 with pend=1 -> all outputs zero immediately, grant_count=0, in_ready=1, no grant for code 1 afterward.

Source files
------------

// File: rtl/onehot_dispatch_decoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dispatch_decoder
// Description : Accepts 3-bit binary indices via a valid/ready handshake and
//               issues each one as a one-hot grant held for HOLD_CYCLES
//               cycles. Every grant is followed by a single idle gap cycle.
//               A one-entry pending register queues a request that arrives
//               while a grant is active, so grants issue strictly in arrival
//               order.
// Ports       : clk          - single clock, rising edge
//               rst          - asynchronous active-high reset
//               in_valid     - requester presents in_code
//               in_code[2:0] - binary index to decode
//               in_ready     - block can take in_code this cycle
//               out_onehot   - 1 << active code while granting, else zero
//               out_valid    - grant active
//               done         - pulse on the last cycle of a grant
//               busy         - grant, gap or pending entry outstanding
//               grant_count  - completed grants (wraps at 16 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_dispatch_decoder #(
   parameter int HOLD_CYCLES = 4   // legal range 1..256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [2:0]  in_code,
   output logic        in_ready,
   output logic [7:0]  out_onehot,
   output logic        out_valid,
   output logic        done,
   output logic        busy,
   output logic [15:0] grant_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   // Counter is loaded with HOLD_CYCLES-1 and the grant ends when it reads
   // zero, so 8 bits cover the full 1..256 range.
   localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD_CYCLES - 1);

   state_t      r_state,       w_state_nxt;
   logic [2:0]  r_code,        w_code_nxt;
   logic [7:0]  r_cnt,         w_cnt_nxt;
   logic        r_pend_valid,  w_pend_valid_nxt;
   logic [2:0]  r_pend_code,   w_pend_code_nxt;
   logic [15:0] r_grant_count, w_grant_count_nxt;

   logic        w_xfer;
   logic        w_active;

   // Ready depends only on the pending slot, so a pending drain and a new
   // acceptance can never coincide on the same edge.
   assign in_ready = !r_pend_valid;
   assign w_xfer   = in_valid && in_ready;
   assign w_active = (r_state == ST_ACTIVE);

   assign out_valid   = w_active;
   assign out_onehot  = w_active ? (8'b1 << r_code) : 8'b0;
   assign done        = w_active && (r_cnt == 8'd0);
   assign busy        = (r_state != ST_IDLE) || r_pend_valid;
   assign grant_count = r_grant_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_code        <= 3'd0;
         r_cnt         <= 8'd0;
         r_pend_valid  <= 1'b0;
         r_pend_code   <= 3'd0;
         r_grant_count <= 16'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_code        <= w_code_nxt;
         r_cnt         <= w_cnt_nxt;
         r_pend_valid  <= w_pend_valid_nxt;
         r_pend_code   <= w_pend_code_nxt;
         r_grant_count <= w_grant_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_code_nxt        = r_code;
      w_cnt_nxt         = r_cnt;
      w_pend_valid_nxt  = r_pend_valid;
      w_pend_code_nxt   = r_pend_code;
      w_grant_count_nxt = r_grant_count;

      case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               w_state_nxt = ST_ACTIVE;
               w_code_nxt  = in_code;
               w_cnt_nxt   = c_HOLD_LOAD;
            end
         end

         ST_ACTIVE: begin
            // A request arriving mid-grant waits in the pending slot.
            if (w_xfer) begin
               w_pend_valid_nxt = 1'b1;
               w_pend_code_nxt  = in_code;
            end
            // Counter holds at zero on the final cycle instead of wrapping.
            if (r_cnt == 8'd0) begin
               w_state_nxt = ST_GAP;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end

         ST_GAP: begin
            w_grant_count_nxt = r_grant_count + 16'd1;
            // The pending entry is older than anything on the input, so it
            // goes first; in_ready is low while it exists.
            if (r_pend_valid) begin
               w_state_nxt      = ST_ACTIVE;
               w_code_nxt       = r_pend_code;
               w_cnt_nxt        = c_HOLD_LOAD;
               w_pend_valid_nxt = 1'b0;
            end else if (w_xfer) begin
               w_state_nxt = ST_ACTIVE;
               w_code_nxt  = in_code;
               w_cnt_nxt   = c_HOLD_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_onehot_dispatch_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_dispatch_decoder
// Description : Directed bench for onehot_dispatch_decoder. One instance runs
//               with HOLD_CYCLES=4, a second with HOLD_CYCLES=1. Accepted
//               codes are queued as they are handed over; a monitor pops the
//               queue at the start of each grant and checks the one-hot value
//               and the grant length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_dispatch_decoder;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [2:0]  in_code = 3'd0;
   logic        in_ready;
   logic [7:0]  out_onehot;
   logic        out_valid;
   logic        done;
   logic        busy;
   logic [15:0] grant_count;

   logic        in_valid1 = 1'b0;
   logic [2:0]  in_code1 = 3'd0;
   logic        in_ready1;
   logic [7:0]  out_onehot1;
   logic        out_valid1;
   logic        done1;
   logic        busy1;
   logic [15:0] grant_count1;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [2:0]  q[$];

   onehot_dispatch_decoder #(.HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
      .in_ready(in_ready), .out_onehot(out_onehot), .out_valid(out_valid),
      .done(done), .busy(busy), .grant_count(grant_count)
   );

   onehot_dispatch_decoder #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_code(in_code1),
      .in_ready(in_ready1), .out_onehot(out_onehot1), .out_valid(out_valid1),
      .done(done1), .busy(busy1), .grant_count(grant_count1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a code, wait (bounded) for acceptance, record it as expected.
   task automatic send(input logic [2:0] code);
      in_valid = 1'b1;
      in_code  = code;
      for (int t = 0; t < 200; t++) begin
         if (in_ready) begin
            q.push_back(code);
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
      end
      in_valid = 1'b0;
      chk("send_timeout", 32'd1, {31'd0, in_ready});
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 200) begin
         tick();
         t++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   // Scoreboard monitor for the HOLD=4 instance.
   logic [2:0] m_code = 3'd0;
   int         m_run  = 0;

   always @(negedge clk) begin
      if (rst) begin
         m_run = 0;
      end else if (out_valid) begin
         if (m_run == 0) begin
            n_cmp++;
            assert (q.size() != 0) else begin
               n_err++;
               $error("FAIL unexpected_grant: observed onehot %0h required no grant", out_onehot);
            end
            if (q.size() != 0) m_code = q.pop_front();
         end
         chk("grant_onehot", {24'd0, out_onehot}, {24'd0, 8'b1 << m_code});
         m_run++;
         if (done) begin
            chk("grant_length", m_run, HOLD);
            m_run = 0;
         end
      end else begin
         chk("idle_onehot", {24'd0, out_onehot}, 32'd0);
         chk("idle_done", {31'd0, done}, 32'd0);
         if (m_run != 0) begin
            chk("grant_no_done", m_run, HOLD);
            m_run = 0;
         end
      end
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_onehot", {24'd0, out_onehot}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_count", {16'd0, grant_count}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // Single grant of code 5
      send(3'd5);                                           // cycle 1
      chk("single_c1", {24'd0, out_onehot}, 32'h20);
      chk("single_busy", {31'd0, busy}, 32'd1);
      repeat (3) tick();                                    // cycle 4
      chk("single_done", {31'd0, done}, 32'd1);
      chk("single_c4", {24'd0, out_onehot}, 32'h20);
      tick();                                               // cycle 5 gap
      chk("single_gap", {24'd0, out_onehot}, 32'd0);
      chk("single_gap_busy", {31'd0, busy}, 32'd1);
      tick();                                               // cycle 6 idle
      chk("single_idle", {31'd0, busy}, 32'd0);
      chk("single_count", {16'd0, grant_count}, 32'd1);

      // Back-to-back: code 7 lands in the pending slot
      send(3'd2);                                           // cycle 1
      send(3'd7);                                           // cycle 2
      chk("b2b_ready_low", {31'd0, in_ready}, 32'd0);
      chk("b2b_onehot", {24'd0, out_onehot}, 32'h04);
      repeat (3) tick();                                    // cycle 5 gap
      chk("b2b_gap", {24'd0, out_onehot}, 32'd0);
      chk("b2b_gap_ready", {31'd0, in_ready}, 32'd0);
      tick();                                               // cycle 6
      chk("b2b_second", {24'd0, out_onehot}, 32'h80);
      chk("b2b_ready_back", {31'd0, in_ready}, 32'd1);
      repeat (5) tick();                                    // cycle 11
      chk("b2b_idle", {31'd0, busy}, 32'd0);
      chk("b2b_count", {16'd0, grant_count}, 32'd3);

      // Bypass: code 3 offered during the gap after code 0
      send(3'd0);                                           // cycle 1
      repeat (4) tick();                                    // cycle 5 gap
      chk("byp_gap_valid", {31'd0, out_valid}, 32'd0);
      send(3'd3);                                           // cycle 6
      chk("byp_start", {24'd0, out_onehot}, 32'h08);
      repeat (5) tick();                                    // cycle 11
      chk("byp_idle", {31'd0, busy}, 32'd0);
      chk("byp_count", {16'd0, grant_count}, 32'd5);

      // Backpressure: stream 1,2,3 with in_valid held high
      send(3'd1);
      send(3'd2);
      send(3'd3);
      wait_idle();
      chk("bp_count", {16'd0, grant_count}, 32'd8);

      // HOLD_CYCLES=1 instance: codes 6,6
      in_valid1 = 1'b1;
      in_code1  = 3'd6;
      tick();                                               // cycle 1
      chk("h1_c1", {24'd0, out_onehot1}, 32'h40);
      chk("h1_c1_done", {31'd0, done1}, 32'd1);
      chk("h1_c1_ready", {31'd0, in_ready1}, 32'd1);
      tick();                                               // cycle 2 gap
      in_valid1 = 1'b0;
      chk("h1_c2", {24'd0, out_onehot1}, 32'd0);
      chk("h1_c2_done", {31'd0, done1}, 32'd0);
      chk("h1_c2_ready", {31'd0, in_ready1}, 32'd0);
      tick();                                               // cycle 3
      chk("h1_c3", {24'd0, out_onehot1}, 32'h40);
      chk("h1_c3_done", {31'd0, done1}, 32'd1);
      tick();                                               // cycle 4 gap
      chk("h1_c4", {24'd0, out_onehot1}, 32'd0);
      tick();                                               // cycle 5 idle
      chk("h1_idle", {31'd0, busy1}, 32'd0);
      chk("h1_count", {16'd0, grant_count1}, 32'd2);

      // Reset mid-grant with code 1 pending
      send(3'd4);                                           // cycle 1
      send(3'd1);                                           // cycle 2
      chk("rm_pend_ready", {31'd0, in_ready}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("rm_onehot", {24'd0, out_onehot}, 32'd0);
      chk("rm_valid", {31'd0, out_valid}, 32'd0);
      chk("rm_done", {31'd0, done}, 32'd0);
      chk("rm_count", {16'd0, grant_count}, 32'd0);
      chk("rm_ready", {31'd0, in_ready}, 32'd1);
      chk("rm_busy", {31'd0, busy}, 32'd0);
      q.delete();
      #3 rst = 1'b0;
      repeat (8) tick();
      chk("rm_after_busy", {31'd0, busy}, 32'd0);
      chk("rm_after_count", {16'd0, grant_count}, 32'd0);

      chk("queue_drained", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
